// File: rtl/memory_write_pkg.sv
// Shared types and constants for the CNN result write-back engine.
// The package is named cnn_mem_pkg so that memory_read can share the bank geometry.
package cnn_mem_pkg;

  // Number of interleaved image RAM banks, and the index bits that select a bank
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } wb_state_t;

  // One-hot write enable for the bank that owns a given result index
  function automatic logic [NUM_BANKS-1:0] bankOneHot(input logic [BANK_W-1:0] bank);
    bankOneHot       = '0;
    bankOneHot[bank] = 1'b1;
  endfunction

endpackage

// File: rtl/memory_write_if.sv
// Result stream handshake from the MAC/SSFR stage into the write-back engine.
// The master drives valid/data; the slave (memory_write) drives ready.
interface memory_write_if #(
  parameter int DATA_W = 8
);

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  modport master (
    output res_valid,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready
  );

endinterface

// File: rtl/memory_write_fifo.sv
// wb_fifo: small synchronous FIFO holding {result index, result data} entries
// while the read side owns the shared RAM port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wrPtr_q;
  logic [PTR_W:0]    rdPtr_q;
  logic              doPush;
  logic              doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rdPtr_q[PTR_W-1:0]];

  // Pointer update; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/memory_write.sv
// memory_write: write-back engine storing the 8-bit CNN result stream into four
// interleaved image RAM banks. Result i lands in bank i%4 at base_addr + i/4.
// Optional feature: define MEM_WRITE_RELU_EN to clamp negative results to zero
// as they enter the FIFO; timing is identical with or without it.
module memory_write
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [CNT_W-1:0]     num_results_i,
  memory_write_if.slave        res_if,
  input  logic                 mem_busy_i,
  output logic [NUM_BANKS-1:0] wr_en_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [DATA_W-1:0]    wr_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     wr_count_o
);

  localparam int ENTRY_W = CNT_W + DATA_W;

  wb_state_t             state_q;
  logic [ADDR_W-1:0]     baseAddr_q;
  logic [CNT_W-1:0]      numResults_q;
  logic [CNT_W-1:0]      accepted_q;
  logic [CNT_W-1:0]      wrCount_q;
  logic [NUM_BANKS-1:0]  wrEn_q;
  logic [ADDR_W-1:0]     wrAddr_q;
  logic [DATA_W-1:0]     wrData_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  resReady;
  logic                  push;
  logic                  pop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [DATA_W-1:0]     pushData;
  logic [ENTRY_W-1:0]    fifoDin;
  logic [ENTRY_W-1:0]    fifoDout;
  logic [CNT_W-1:0]      headIdx;
  logic [DATA_W-1:0]     headData;
  logic [NUM_BANKS-1:0]  wrEn_d;
  logic [ADDR_W-1:0]     wrAddr_d;

  // Ready depends on registers only, so a full FIFO refuses a beat even if it pops this cycle
  assign resReady         = (state_q == RUN) && !fifoFull && (accepted_q < numResults_q);
  assign res_if.res_ready = resReady;
  assign push             = res_if.res_valid && resReady;

  // Drain only while a layer is active and the read side has released the RAM port
  assign pop = busy_q && !fifoEmpty && !mem_busy_i;

`ifdef MEM_WRITE_RELU_EN
  assign pushData = res_if.res_data[DATA_W-1] ? '0 : res_if.res_data;
`else
  assign pushData = res_if.res_data;
`endif

  assign fifoDin  = {accepted_q, pushData};
  assign headIdx  = fifoDout[ENTRY_W-1:DATA_W];
  assign headData = fifoDout[DATA_W-1:0];

  // Bank select from the low index bits, row address from the rest; the sum wraps at ADDR_W
  assign wrEn_d   = bankOneHot(headIdx[BANK_W-1:0]);
  assign wrAddr_d = baseAddr_q + ADDR_W'(headIdx >> BANK_W);

  wb_fifo #(
    .DATA_W     (ENTRY_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifoDin),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Layer control FSM plus the registered RAM write port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      baseAddr_q   <= '0;
      numResults_q <= '0;
      accepted_q   <= '0;
      wrCount_q    <= '0;
      wrEn_q       <= '0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrEn_q <= '0;

      if (pop) begin
        wrEn_q    <= wrEn_d;
        wrAddr_q  <= wrAddr_d;
        wrData_q  <= headData;
        wrCount_q <= wrCount_q + CNT_W'(1);
      end

      if (push) accepted_q <= accepted_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (start_i) begin
            baseAddr_q   <= base_addr_i;
            numResults_q <= num_results_i;
            accepted_q   <= '0;
            wrCount_q    <= '0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (accepted_q == numResults_q) state_q <= FLUSH;
        end
        FLUSH: begin
          // Empty here means the final pop has already produced its registered write
          if (fifoEmpty) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_en_o    = wrEn_q;
  assign wr_addr_o  = wrAddr_q;
  assign wr_data_o  = wrData_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_count_o = wrCount_q;

endmodule

// File: tb/tb_memory_write.sv
// Self-checking bench for memory_write. Accepted beats push their expected RAM
// write onto a scoreboard queue; every observed write pops and compares.
module tb_memory_write;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

`ifdef MEM_WRITE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [3:0]        wrEn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrExp_t;

  typedef struct {
    logic [DATA_W-1:0] resData;
    logic [3:0]        expWrEn;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [CNT_W-1:0]  num_results_i;
  logic              mem_busy_i;
  logic [3:0]        wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  wr_count_o;

  memory_write_if #(.DATA_W(DATA_W)) resIf ();

  memory_write #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_results_i (num_results_i),
    .res_if        (resIf),
    .mem_busy_i    (mem_busy_i),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .wr_count_o    (wr_count_o)
  );

  always #5 clk = ~clk;

  wrExp_t            expQ[$];
  logic [DATA_W-1:0] txData[$];
  vec_t              vecs[8];

  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                startCyc = 0;
  int                doneCyc = 0;
  int                lastWrCyc = 0;
  int                writesSeen = 0;
  int                acceptCnt = 0;
  int                doneCount = 0;
  int                busyViolations = 0;
  int                addrZeroHits = 0;
  int                busyCycles = 0;
  int                bankHits[4];
  logic              busyPrev = 1'b0;
  logic              useModel = 1'b1;
  logic [ADDR_W-1:0] modelBase = '0;
  logic [CNT_W-1:0]  modelIdx = '0;
  bit                sawDone;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] d);
    if (RELU && d[DATA_W-1]) return '0;
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual='h%0h required='h%0h", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    writesSeen     = 0;
    acceptCnt      = 0;
    doneCount      = 0;
    busyViolations = 0;
    addrZeroHits   = 0;
    for (int b = 0; b < 4; b++) bankHits[b] = 0;
  endtask

  // Present the head of the transmit queue and the mem_busy schedule for one cycle
  task automatic driveInputs();
    if (busyCycles > 0) begin
      mem_busy_i = 1'b1;
      busyCycles--;
    end else begin
      mem_busy_i = 1'b0;
    end
    if (txData.size() > 0) begin
      resIf.res_valid = 1'b1;
      resIf.res_data  = txData[0];
    end else begin
      resIf.res_valid = 1'b0;
      resIf.res_data  = '0;
    end
  endtask

  task automatic applyStimulus(input int maxCycles, input bit stopOnDone, output bit seenDone);
    seenDone = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      driveInputs();
      if (stopOnDone && done_o) begin
        seenDone = 1'b1;
        break;
      end
    end
  endtask

  task automatic startLayer(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] num, input bit taken);
    @(negedge clk);
    driveInputs();
    start_i       = 1'b1;
    base_addr_i   = base;
    num_results_i = num;
    startCyc      = cyc;
    if (taken) begin
      modelBase = base;
      modelIdx  = '0;
    end
    @(negedge clk);
    driveInputs();
    start_i = 1'b0;
  endtask

  // Accept monitor: record each handshake and predict the write it must cause
  always @(posedge clk) begin
    cyc++;
    busyPrev = mem_busy_i;
    if (resIf.res_valid && resIf.res_ready) begin
      wrExp_t e;
      acceptCnt++;
      if (useModel) begin
        e.wrEn = 4'b0001 << modelIdx[1:0];
        e.addr = modelBase + ADDR_W'(modelIdx >> 2);
        e.data = relu(resIf.res_data);
        expQ.push_back(e);
        modelIdx++;
      end
      if (txData.size() > 0) void'(txData.pop_front());
    end
  end

  // Write monitor: compare every RAM write against the scoreboard head
  always @(negedge clk) begin
    wrExp_t e;
    if (done_o) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (wr_en_o != 4'b0000) begin
      writesSeen++;
      lastWrCyc = cyc;
      if (busyPrev) busyViolations++;
      for (int b = 0; b < 4; b++) if (wr_en_o[b]) bankHits[b]++;
      if (wr_addr_o == '0) addrZeroHits++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(wr_en_o), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_en", 32'(wr_en_o), 32'(e.wrEn));
        checkOutput("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        checkOutput("wr_data", 32'(wr_data_o), 32'(e.data));
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_wr_count"}, 32'(wr_count_o), 32'd0);
    checkOutput({tag, "_res_ready"}, 32'(resIf.res_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    start_i         = 1'b0;
    base_addr_i     = '0;
    num_results_i   = '0;
    mem_busy_i      = 1'b0;
    resIf.res_valid = 1'b0;
    resIf.res_data  = '0;
    for (int b = 0; b < 4; b++) bankHits[b] = 0;

    // Table for the first layer: base 100, results 0..7, including negative bytes
    vecs[0] = '{8'h11, 4'b0001, 14'd100, 8'h11};
    vecs[1] = '{8'h22, 4'b0010, 14'd100, 8'h22};
    vecs[2] = '{8'h7F, 4'b0100, 14'd100, 8'h7F};
    vecs[3] = '{8'h80, 4'b1000, 14'd100, RELU ? 8'h00 : 8'h80};
    vecs[4] = '{8'h00, 4'b0001, 14'd101, 8'h00};
    vecs[5] = '{8'hF3, 4'b0010, 14'd101, RELU ? 8'h00 : 8'hF3};
    vecs[6] = '{8'h01, 4'b0100, 14'd101, 8'h01};
    vecs[7] = '{8'hFF, 4'b1000, 14'd101, RELU ? 8'h00 : 8'hFF};

    repeat (3) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Layer 1: streaming every cycle, plus two excess beats that must stay unconsumed
    $display("[TB] layer 1: num=8 base=100 streaming");
    clearStats();
    useModel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wrExp_t e;
      e.wrEn = vecs[i].expWrEn;
      e.addr = vecs[i].expAddr;
      e.data = vecs[i].expData;
      expQ.push_back(e);
      txData.push_back(vecs[i].resData);
    end
    txData.push_back(8'hAA);
    txData.push_back(8'hBB);
    startLayer(14'd100, 16'd8, 1'b1);
    applyStimulus(60, 1'b1, sawDone);
    #1;
    checkOutput("l1_done_seen", 32'(sawDone), 32'd1);
    checkOutput("l1_writes", 32'(writesSeen), 32'd8);
    checkOutput("l1_done_latency", 32'(doneCyc - lastWrCyc), 32'd1);
    checkOutput("l1_wr_count", 32'(wr_count_o), 32'd8);
    checkOutput("l1_excess_left", 32'(txData.size()), 32'd2);
    checkOutput("l1_scoreboard_empty", 32'(expQ.size()), 32'd0);
    txData.delete();
    useModel = 1'b1;
    applyStimulus(3, 1'b0, sawDone);
    #1;
    checkOutput("l1_idle_busy", 32'(busy_o), 32'd0);
    checkOutput("l1_done_pulses", 32'(doneCount), 32'd1);

    // Layer 2: RAM port held by the read side, FIFO must fill and stall the stream
    $display("[TB] layer 2: num=6 with mem_busy");
    clearStats();
    for (int i = 0; i < 6; i++) txData.push_back(8'(8'h40 + i));
    busyCycles = 10;
    startLayer(14'd200, 16'd6, 1'b1);
    applyStimulus(6, 1'b0, sawDone);
    #1;
    checkOutput("l2_accepts_while_busy", 32'(acceptCnt), 32'd4);
    checkOutput("l2_ready_when_full", 32'(resIf.res_ready), 32'd0);
    checkOutput("l2_writes_while_busy", 32'(writesSeen), 32'd0);
    applyStimulus(60, 1'b1, sawDone);
    #1;
    checkOutput("l2_done_seen", 32'(sawDone), 32'd1);
    checkOutput("l2_writes", 32'(writesSeen), 32'd6);
    checkOutput("l2_busy_violations", 32'(busyViolations), 32'd0);
    checkOutput("l2_done_latency", 32'(doneCyc - lastWrCyc), 32'd1);
    checkOutput("l2_wr_count", 32'(wr_count_o), 32'd6);
    checkOutput("l2_scoreboard_empty", 32'(expQ.size()), 32'd0);

    // Layer 3: address wrap at the top of the bank address space
    $display("[TB] layer 3: num=12 base=3FFE wrap");
    clearStats();
    for (int i = 0; i < 12; i++) txData.push_back(8'($urandom_range(0, 255)));
    startLayer(14'h3FFE, 16'd12, 1'b1);
    applyStimulus(80, 1'b1, sawDone);
    #1;
    checkOutput("l3_done_seen", 32'(sawDone), 32'd1);
    checkOutput("l3_writes", 32'(writesSeen), 32'd12);
    for (int b = 0; b < 4; b++) checkOutput($sformatf("l3_bank%0d_hits", b), 32'(bankHits[b]), 32'd3);
    checkOutput("l3_addr_zero_hits", 32'(addrZeroHits), 32'd4);
    checkOutput("l3_scoreboard_empty", 32'(expQ.size()), 32'd0);

    // Layer 4: empty layer, done exactly three cycles after start
    $display("[TB] layer 4: num=0");
    clearStats();
    startLayer(14'd5, 16'd0, 1'b1);
    applyStimulus(10, 1'b1, sawDone);
    #1;
    checkOutput("l4_done_seen", 32'(sawDone), 32'd1);
    checkOutput("l4_done_after_start", 32'(doneCyc - startCyc), 32'd3);
    checkOutput("l4_writes", 32'(writesSeen), 32'd0);
    checkOutput("l4_wr_count", 32'(wr_count_o), 32'd0);
    applyStimulus(2, 1'b0, sawDone);

    // Layer 5: a second start during the layer must not disturb base or count
    $display("[TB] layer 5: start while busy");
    clearStats();
    for (int i = 0; i < 3; i++) txData.push_back(8'(8'h60 + i));
    startLayer(14'd50, 16'd3, 1'b1);
    applyStimulus(1, 1'b0, sawDone);
    startLayer(14'd500, 16'd1, 1'b0);
    applyStimulus(40, 1'b1, sawDone);
    #1;
    checkOutput("l5_done_seen", 32'(sawDone), 32'd1);
    checkOutput("l5_writes", 32'(writesSeen), 32'd3);
    checkOutput("l5_wr_count", 32'(wr_count_o), 32'd3);
    checkOutput("l5_scoreboard_empty", 32'(expQ.size()), 32'd0);
    applyStimulus(2, 1'b0, sawDone);

    // Layer 6: reset part-way through, then a fresh short layer
    $display("[TB] layer 6: reset mid-layer");
    clearStats();
    for (int i = 0; i < 8; i++) txData.push_back(8'(8'h70 + i));
    startLayer(14'd300, 16'd8, 1'b1);
    for (int i = 0; i < 50 && writesSeen < 3; i++) begin
      applyStimulus(1, 1'b0, sawDone);
      #1;
    end
    checkOutput("l6_writes_before_reset", 32'(writesSeen), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    txData.delete();
    driveInputs();
    @(negedge clk);
    driveInputs();
    #1;
    expQ.delete();
    checkIdleOutputs("l6_reset");
    checkOutput("l6_no_done", 32'(doneCount), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clearStats();
    applyStimulus(5, 1'b0, sawDone);
    #1;
    checkOutput("l6_no_stale_writes", 32'(writesSeen), 32'd0);
    txData.push_back(8'h12);
    txData.push_back(8'h34);
    startLayer(14'd400, 16'd2, 1'b1);
    applyStimulus(40, 1'b1, sawDone);
    #1;
    checkOutput("l6_done_seen", 32'(sawDone), 32'd1);
    checkOutput("l6_fresh_writes", 32'(writesSeen), 32'd2);
    checkOutput("l6_wr_count", 32'(wr_count_o), 32'd2);
    checkOutput("l6_scoreboard_empty", 32'(expQ.size()), 32'd0);
    applyStimulus(3, 1'b0, sawDone);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
